navigation_sequencer: RTL

NAVIGATION_SEQUENCER -- requirements
Module: navigation_sequencer

---
 rtl/navigation_sequencer_pkg.sv | 37 +++
 rtl/navigation_sequencer_wait_timer.sv | 37 +++
 rtl/navigation_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/navigation_sequencer_pkg.sv
// Shared definitions for the navigation sequencer: state encoding, the
// "arrived" command constant and small helpers used by the control logic.
package navigation_sequencer_pkg;

  localparam int unsigned CMD_W      = 12;
  localparam int unsigned LOC_W      = 12;
  localparam int unsigned TARGET_W   = 4;
  localparam int unsigned MOVE_CNT_W = 4;

  // A calculator result of all zeroes means the rover is already at the target.
  localparam logic [CMD_W-1:0] CMD_ARRIVED = '0;

  typedef enum logic [2:0] {
    NAV_IDLE    = 3'd0,
    NAV_MEASURE = 3'd1,
    NAV_CALC    = 3'd2,
    NAV_SEND    = 3'd3,
    NAV_SETTLE  = 3'd4,
    NAV_DONE    = 3'd5,
    NAV_FAULT   = 3'd6
  } nav_state_t;

  // States that belong to an active run.
  function automatic logic state_is_busy(input nav_state_t s);
    return (s == NAV_MEASURE) || (s == NAV_CALC) ||
           (s == NAV_SEND)    || (s == NAV_SETTLE);
  endfunction

  // Counter width able to hold the larger of the two wait lengths.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/navigation_sequencer_wait_timer.sv
// Loadable down-counter. expired is high while the count sits at zero; a load
// of N-1 therefore flags expiry on the N-th cycle after the load edge.
module wait_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload on request, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/navigation_sequencer.sv
// Rover navigation sequencer: measure position, ask the path calculator for a
// move, transmit it over IR, wait for the rover to settle, repeat until the
// calculator reports arrival, the move budget runs out or a wait times out.
module navigation_sequencer
  import navigation_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27000000,
  parameter int unsigned SETTLE_CYCLES  = 13500000,
  parameter int unsigned MAX_MOVES      = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TARGET_W-1:0]   target_location,
  input  logic                  location_valid,
  input  logic [LOC_W-1:0]      rover_location,
  input  logic                  calc_done,
  input  logic [CMD_W-1:0]      calc_command,
  input  logic                  tx_done,
  output logic                  measure_start,
  output logic                  calc_enable,
  output logic [LOC_W-1:0]      calc_rover_location,
  output logic [TARGET_W-1:0]   calc_target_location,
  output logic                  tx_start,
  output logic [CMD_W-1:0]      tx_command,
  output logic                  busy,
  output logic                  arrived,
  output logic                  error,
  output logic [MOVE_CNT_W-1:0] move_count
);

  localparam int unsigned            TMR_W        = timer_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [TMR_W-1:0]       TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]       SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [MOVE_CNT_W-1:0]  MAX_MOVES_C  = MOVE_CNT_W'(MAX_MOVES);

  nav_state_t            state_q, state_d;
  logic [TARGET_W-1:0]   target_q, target_d;
  logic [LOC_W-1:0]      rover_q, rover_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic [MOVE_CNT_W-1:0] move_count_q, move_count_d;
  logic                  arrived_q, arrived_d;
  logic                  error_q, error_d;
  logic                  measure_start_q, measure_start_d;
  logic                  tx_start_q, tx_start_d;
  logic                  calc_enable_q, calc_enable_d;
  logic                  busy_q, busy_d;

  logic                  entering;
  logic                  timer_load;
  logic [TMR_W-1:0]      timer_value;
  logic                  timer_expired;

  // One timer serves both the per-state timeout and the settle delay; it is
  // reloaded on every entry into a timed state.
  wait_timer #(
    .WIDTH(TMR_W)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .expired   (timer_expired)
  );

  // Next-state and datapath decisions; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    rover_d      = rover_q;
    cmd_d        = cmd_q;
    move_count_d = move_count_q;
    arrived_d    = arrived_q;
    error_d      = error_q;

    if (abort) begin
      state_d   = NAV_IDLE;
      arrived_d = 1'b0;
      error_d   = 1'b0;
    end else begin
      case (state_q)
        NAV_IDLE, NAV_DONE, NAV_FAULT: begin
          if (start) begin
            state_d      = NAV_MEASURE;
            target_d     = target_location;
            move_count_d = '0;
            arrived_d    = 1'b0;
            error_d      = 1'b0;
          end
        end
        NAV_MEASURE: begin
          if (location_valid) begin
            rover_d = rover_location;
            state_d = NAV_CALC;
          end else if (timer_expired) begin
            state_d = NAV_FAULT;
            error_d = 1'b1;
          end
        end
        NAV_CALC: begin
          if (calc_done) begin
            if (calc_command == CMD_ARRIVED) begin
              state_d   = NAV_DONE;
              arrived_d = 1'b1;
            end else begin
              cmd_d   = calc_command;
              state_d = NAV_SEND;
              if (move_count_q < MAX_MOVES_C) begin
                move_count_d = move_count_q + 1'b1;
              end
            end
          end else if (timer_expired) begin
            state_d = NAV_FAULT;
            error_d = 1'b1;
          end
        end
        NAV_SEND: begin
          if (tx_done) begin
            state_d = NAV_SETTLE;
          end else if (timer_expired) begin
            state_d = NAV_FAULT;
            error_d = 1'b1;
          end
        end
        NAV_SETTLE: begin
          if (timer_expired) begin
            if (move_count_q < MAX_MOVES_C) begin
              state_d = NAV_MEASURE;
            end else begin
              state_d = NAV_FAULT;
              error_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = NAV_IDLE;
        end
      endcase
    end

    // Outputs are derived from the next state so that, once registered, the
    // pulses land on the first cycle of the new state.
    entering        = (state_d != state_q);
    timer_load      = entering && (state_is_busy(state_d));
    timer_value     = (state_d == NAV_SETTLE) ? SETTLE_LOAD : TIMEOUT_LOAD;
    measure_start_d = entering && (state_d == NAV_MEASURE);
    tx_start_d      = entering && (state_d == NAV_SEND);
    calc_enable_d   = (state_d == NAV_CALC);
    busy_d          = state_is_busy(state_d);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= NAV_IDLE;
      target_q        <= '0;
      rover_q         <= '0;
      cmd_q           <= '0;
      move_count_q    <= '0;
      arrived_q       <= 1'b0;
      error_q         <= 1'b0;
      measure_start_q <= 1'b0;
      tx_start_q      <= 1'b0;
      calc_enable_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      rover_q         <= rover_d;
      cmd_q           <= cmd_d;
      move_count_q    <= move_count_d;
      arrived_q       <= arrived_d;
      error_q         <= error_d;
      measure_start_q <= measure_start_d;
      tx_start_q      <= tx_start_d;
      calc_enable_q   <= calc_enable_d;
      busy_q          <= busy_d;
    end
  end

  assign measure_start        = measure_start_q;
  assign calc_enable          = calc_enable_q;
  assign calc_rover_location  = rover_q;
  assign calc_target_location = target_q;
  assign tx_start             = tx_start_q;
  assign tx_command           = cmd_q;
  assign busy                 = busy_q;
  assign arrived              = arrived_q;
  assign error                = error_q;
  assign move_count           = move_count_q;

endmodule
